// File: rtl/adc_pkg.sv
// Shared definitions for the ADC acquisition path: Q16.16 scaling, pacing
// limit, FSM state encodings and the 35-bit to 32-bit saturation helper.
package adc_pkg;

  localparam int FRAC_BITS          = 16;
  localparam int MIN_PERIOD_DEFAULT = 240;

  typedef enum logic {
    CV_IDLE,
    CV_WAIT
  } cv_state_t;

  typedef enum logic {
    CAP_IDLE,
    CAP_RUN
  } cap_state_t;

  // Clamp a 35-bit signed sum into the signed 32-bit range.
  function automatic logic [31:0] sat32(input logic signed [34:0] v);
    logic [3:0] hi;
    hi = v[34:31];
    if (hi == 4'b0000 || hi == 4'b1111) return v[31:0];
    return v[34] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  endfunction

endpackage

// File: rtl/adc_cal_pipe.sv
// Gain/offset calibration: stage 1 registers raw*gain, stage 2 shifts, adds the
// offset and saturates; the stage-2 result is registered by whoever consumes it.
module adc_cal_pipe
  import adc_pkg::*;
#(
  parameter int ADC_WIDTH = 18
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [ADC_WIDTH-1:0] i_raw,
  input  logic [31:0]          i_gain,
  input  logic [31:0]          i_offset,
  output logic                 o_valid,
  output logic [31:0]          o_data
);

  localparam int PW = ADC_WIDTH + 32;

  logic signed [PW-1:0] raw_ext;
  logic signed [PW-1:0] gain_ext;
  logic signed [PW-1:0] prod_q;
  logic                 s1_valid;
  logic signed [34:0]   quot;
  logic signed [34:0]   sum;

  assign raw_ext  = {{32{i_raw[ADC_WIDTH-1]}}, i_raw};
  assign gain_ext = {{ADC_WIDTH{i_gain[31]}}, i_gain};

  // NOTE: clocked state uses <= so every register samples pre-edge values;
  // blocking assignments here would make results depend on statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      prod_q   <= '0;
    end else begin
      s1_valid <= i_valid;
      if (i_valid) prod_q <= raw_ext * gain_ext;
    end
  end

  // Arithmetic shift floors toward -inf; the quotient always fits in 34 bits.
  assign quot    = 35'(prod_q >>> FRAC_BITS);
  assign sum     = quot + {{3{i_offset[31]}}, i_offset};
  assign o_valid = s1_valid;
  assign o_data  = sat32(sum);

endmodule

// File: rtl/adc_acq_ctrl.sv
// ADC acquisition controller: paces conversions, calibrates samples and streams
// a fixed-length capture to the DDR writer with overrun/overflow reporting.
module adc_acq_ctrl
  import adc_pkg::*;
#(
  parameter int MEM_SIZE   = 10000,
  parameter int ADC_WIDTH  = 18,
  parameter int MIN_PERIOD = MIN_PERIOD_DEFAULT
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [31:0]               i_user_gain,
  input  logic [31:0]               i_user_offset,
  input  logic [9:0]                i_adc_freq,
  input  logic [$clog2(MEM_SIZE):0] i_ddr_size,
  input  logic                      i_cap_start,
  output logic                      o_adc_start,
  input  logic                      i_adc_done,
  input  logic [ADC_WIDTH-1:0]      i_adc_raw,
  output logic [31:0]               o_adc_data,
  output logic                      m_valid,
  output logic [31:0]               m_data,
  output logic                      m_last,
  input  logic                      m_ready,
  output logic                      o_cap_busy,
  output logic                      o_cap_done,
  output logic                      o_overrun,
  output logic                      o_overflow
);

  localparam int            SW         = $clog2(MEM_SIZE) + 1;
  localparam logic [SW-1:0] LEN_MAX    = SW'(MEM_SIZE);
  localparam logic [9:0]    PERIOD_MIN = 10'(MIN_PERIOD);

  // ---------------------------------------------------------------------------
  // Sample pacing: frequency compared live, so a lowered period wraps at once.
  // ---------------------------------------------------------------------------
  logic [9:0] per_cnt;
  logic       per_en;
  logic       tick;

  assign per_en = (i_adc_freq >= PERIOD_MIN);
  assign tick   = per_en && (per_cnt >= i_adc_freq - 10'd1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                per_cnt <= '0;
    else if (!per_en || tick) per_cnt <= '0;
    else                      per_cnt <= per_cnt + 10'd1;
  end

  // ---------------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------------
  cv_state_t cv_state, cv_next;
  logic      start_nxt;
  logic      overrun_set;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cv_state    <= CV_IDLE;
      o_adc_start <= 1'b0;
    end else begin
      cv_state    <= cv_next;
      o_adc_start <= start_nxt;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    cv_next     = cv_state;
    start_nxt   = 1'b0;
    overrun_set = 1'b0;
    case (cv_state)
      CV_IDLE: begin
        if (tick) begin
          cv_next   = CV_WAIT;
          start_nxt = 1'b1;
        end
      end
      CV_WAIT: begin
        if (tick)       overrun_set = 1'b1;
        if (i_adc_done) cv_next     = CV_IDLE;
      end
      default: cv_next = CV_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Calibration; stage 2 lands directly in o_adc_data and the stream register
  // ---------------------------------------------------------------------------
  logic        cal_valid;
  logic [31:0] cal_data;

  adc_cal_pipe #(.ADC_WIDTH(ADC_WIDTH)) u_cal (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_adc_done),
    .i_raw    (i_adc_raw),
    .i_gain   (i_user_gain),
    .i_offset (i_user_offset),
    .o_valid  (cal_valid),
    .o_data   (cal_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          o_adc_data <= '0;
    else if (cal_valid) o_adc_data <= cal_data;
  end

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  cap_state_t cap_state, cap_next;
  logic       cap_enter;
  logic       done_nxt;
  logic       beat_accept;

  assign beat_accept = m_valid && m_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cap_state  <= CAP_IDLE;
      o_cap_done <= 1'b0;
    end else begin
      cap_state  <= cap_next;
      o_cap_done <= done_nxt;
    end
  end

  always_comb begin
    cap_next  = cap_state;
    cap_enter = 1'b0;
    done_nxt  = 1'b0;
    case (cap_state)
      CAP_IDLE: begin
        if (i_cap_start && i_ddr_size != '0) begin
          cap_next  = CAP_RUN;
          cap_enter = 1'b1;
        end
      end
      CAP_RUN: begin
        if (beat_accept && m_last) begin
          cap_next = CAP_IDLE;
          done_nxt = 1'b1;
        end
      end
      default: cap_next = CAP_IDLE;
    endcase
  end

  assign o_cap_busy = (cap_state == CAP_RUN);

  // ---------------------------------------------------------------------------
  // Stream register; results beyond the capture length are silently ignored
  // ---------------------------------------------------------------------------
  logic [SW-1:0] len_q;
  logic [SW-1:0] cnt_q;
  logic          want_load;
  logic          can_load;

  assign want_load = (cap_state == CAP_RUN) && cal_valid && (cnt_q < len_q);
  assign can_load  = !m_valid || beat_accept;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      len_q      <= '0;
      cnt_q      <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      o_overrun  <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (cap_enter) begin
        len_q <= (i_ddr_size > LEN_MAX) ? LEN_MAX : i_ddr_size;
        cnt_q <= '0;
      end else if (want_load && can_load) begin
        cnt_q <= cnt_q + SW'(1);
      end

      if (want_load && can_load) begin
        m_valid <= 1'b1;
        m_data  <= cal_data;
        m_last  <= (cnt_q == len_q - SW'(1));
      end else if (beat_accept) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end

      if (cap_enter)        o_overrun <= 1'b0;
      else if (overrun_set) o_overrun <= 1'b1;

      if (cap_enter)                   o_overflow <= 1'b0;
      else if (want_load && !can_load) o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_acq_ctrl.sv
// Directed bench for adc_acq_ctrl: calibration vector table plus hand-written
// pacing, capture, overflow, overrun and reset sequences.
module tb_adc_acq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] gain, offset;
  logic [9:0]  freq;
  logic [14:0] ddr_size;
  logic        cap_start;
  logic        adc_start;
  logic        done_man = 1'b0, done_auto = 1'b0;
  logic [17:0] raw_man = '0, raw_auto = '0;
  logic        adc_done;
  logic [17:0] adc_raw;
  logic [31:0] adc_data;
  logic        m_valid, m_last, m_ready;
  logic [31:0] m_data;
  logic        cap_busy, cap_done, overrun, overflow;
  logic        resp_en = 1'b0;

  assign adc_done = done_man | done_auto;
  assign adc_raw  = done_auto ? raw_auto : raw_man;

  always #5 clk = ~clk;

  adc_acq_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_user_gain(gain), .i_user_offset(offset),
    .i_adc_freq(freq), .i_ddr_size(ddr_size), .i_cap_start(cap_start),
    .o_adc_start(adc_start), .i_adc_done(adc_done), .i_adc_raw(adc_raw),
    .o_adc_data(adc_data), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready), .o_cap_busy(cap_busy), .o_cap_done(cap_done),
    .o_overrun(overrun), .o_overflow(overflow)
  );

  // Cycle counter and observation of starts, beats and done pulses.
  int          cyc = 0;
  int          start_cnt = 0, last_start_cyc = 0;
  int          done_cnt = 0, done_cyc = 0, last_hs_cyc = 0;
  logic        busy_at_done = 1'b0;
  logic [31:0] beat_q[$];
  logic        last_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (adc_start) begin
      start_cnt      = start_cnt + 1;
      last_start_cyc = cyc;
    end
    if (m_valid && m_ready) begin
      beat_q.push_back(m_data);
      last_q.push_back(m_last);
      last_hs_cyc = cyc;
    end
    if (cap_done) begin
      done_cnt     = done_cnt + 1;
      done_cyc     = cyc;
      busy_at_done = cap_busy;
    end
  end

  // ADC front-end model: answers each start five cycles later with raw+1.
  initial forever begin
    @(negedge clk);
    if (resp_en && adc_start) begin
      repeat (5) @(posedge clk);
      #1 done_auto = 1'b1;
      raw_auto = raw_auto + 18'd1;
      @(posedge clk);
      #1 done_auto = 1'b0;
    end
  end

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done(input logic [17:0] r);
    step();
    done_man = 1'b1;
    raw_man  = r;
    step();
    done_man = 1'b0;
  endtask

  task automatic start_cap(input logic [14:0] n);
    step();
    cap_start = 1'b1;
    ddr_size  = n;
    step();
    cap_start = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (start_cnt >= target) ok = 1'b1;
    end
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (done_cnt >= target) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic [17:0] raw;
    logic [31:0] gain;
    logic [31:0] offset;
    logic [31:0] exp;
  } cal_vec_t;

  cal_vec_t vecs[10];

  initial begin
    bit          ok;
    int          s0, s1, b0, d0, t0, cyc_en, errs, lc;
    logic [31:0] prev;

    vecs[0] = '{18'd1000,   32'h0002_0000, 32'd5,         32'd2005};
    vecs[1] = '{18'h1FFFF,  32'h7FFF_FFFF, 32'd0,         32'h7FFF_FFFF};
    vecs[2] = '{18'h20000,  32'h7FFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[3] = '{18'h3FFFF,  32'h0001_0000, 32'd0,         32'hFFFF_FFFF};
    vecs[4] = '{18'h3FFFF,  32'h0000_8000, 32'd0,         32'hFFFF_FFFF};
    vecs[5] = '{18'd3,      32'h0000_8000, 32'd0,         32'd1};
    vecs[6] = '{18'd0,      32'h1234_5678, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    vecs[7] = '{18'd100,    32'h0001_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    vecs[8] = '{18'h3FF9C,  32'h0001_0000, 32'h8000_0000, 32'h8000_0000};
    vecs[9] = '{18'd5,      32'hFFFF_0000, 32'd10,        32'd5};

    rst = 1'b1; gain = '0; offset = '0; freq = '0; ddr_size = '0;
    cap_start = 1'b0; m_ready = 1'b0;
    repeat (3) step();
    check("reset_flags", {25'd0, adc_start, m_valid, m_last, cap_busy, cap_done, overrun, overflow}, 32'd0);
    check("reset_adc_data", adc_data, 32'd0);
    check("reset_m_data", m_data, 32'd0);
    rst = 1'b0;
    step();

    // Calibration table, including the two-cycle latency on every vector.
    prev = 32'd0;
    for (int i = 0; i < 10; i++) begin
      gain   = vecs[i].gain;
      offset = vecs[i].offset;
      pulse_done(vecs[i].raw);
      check($sformatf("cal_latency_%0d", i), adc_data, prev);
      step();
      check($sformatf("cal_value_%0d", i), adc_data, vecs[i].exp);
      prev = vecs[i].exp;
    end
    check("idle_no_stream", beat_q.size(), 32'd0);

    // Pacing at the minimum period, then a disabled period with a pending conversion.
    gain = 32'h0001_0000; offset = '0; m_ready = 1'b1; resp_en = 1'b1;
    s0 = start_cnt; freq = 10'd240; cyc_en = cyc;
    wait_starts(s0 + 1, 400, ok);
    check("first_start_seen", ok, 1);
    check("first_start_delay", last_start_cyc - cyc_en, 240);
    t0 = last_start_cyc;
    wait_starts(s0 + 2, 400, ok);
    check("second_start_seen", ok, 1);
    check("start_spacing", last_start_cyc - t0, 240);
    freq = 10'd239;
    s1 = start_cnt;
    repeat (600) step();
    check("no_start_239", start_cnt - s1, 0);
    check("inflight_completes", adc_data, 32'd2);
    check("no_overrun_normal", overrun, 0);
    freq = 10'd0; resp_en = 1'b0;

    // ADC stall across a tick.
    freq = 10'd240; s0 = start_cnt;
    wait_starts(s0 + 1, 400, ok);
    check("stall_first_start", ok, 1);
    s1 = start_cnt;
    repeat (300) step();
    check("stall_no_extra_start", start_cnt - s1, 0);
    check("overrun_set", overrun, 1);
    freq = 10'd0;
    pulse_done(18'd0);
    repeat (3) step();

    // Four-beat capture paced by the front-end model.
    resp_en = 1'b1; m_ready = 1'b1; freq = 10'd240;
    b0 = beat_q.size(); d0 = done_cnt;
    start_cap(15'd4);
    check("overrun_cleared", overrun, 0);
    check("busy_in_run", cap_busy, 1);
    wait_done(d0 + 1, 2000, ok);
    freq = 10'd0;
    check("cap4_done_seen", ok, 1);
    check("cap4_beats", beat_q.size() - b0, 4);
    for (int k = 0; k < 4 && b0 + k < beat_q.size(); k++) begin
      check($sformatf("cap4_data_%0d", k), beat_q[b0 + k], 32'(3 + k));
      check($sformatf("cap4_last_%0d", k), last_q[b0 + k], (k == 3) ? 1 : 0);
    end
    check("cap4_done_delay", done_cyc - last_hs_cyc, 1);
    check("cap4_busy_at_done", busy_at_done, 0);
    repeat (20) step();
    resp_en = 1'b0;

    // Zero length is ignored.
    b0 = beat_q.size(); d0 = done_cnt;
    start_cap(15'd0);
    check("size0_not_busy", cap_busy, 0);
    pulse_done(18'd9);
    repeat (5) step();
    check("size0_no_beats", beat_q.size() - b0, 0);
    check("size0_no_done", done_cnt - d0, 0);

    // Oversized request clamps to MEM_SIZE.
    b0 = beat_q.size(); d0 = done_cnt;
    start_cap(15'd12000);
    for (int i = 0; i < 10000; i++) pulse_done(18'(i));
    repeat (5) step();
    pulse_done(18'd5);
    repeat (5) step();
    check("big_beats", beat_q.size() - b0, 10000);
    errs = 0; lc = 0;
    for (int k = 0; k < 10000 && b0 + k < beat_q.size(); k++) begin
      if (beat_q[b0 + k] !== 32'(k)) errs++;
      if (last_q[b0 + k]) lc++;
    end
    check("big_data_errs", errs, 0);
    check("big_last_count", lc, 1);
    check("big_done", done_cnt - d0, 1);
    check("big_no_overflow", overflow, 0);

    // Stalled stream drops samples without counting them.
    m_ready = 1'b0; b0 = beat_q.size(); d0 = done_cnt;
    start_cap(15'd3);
    pulse_done(18'd10);
    pulse_done(18'd11);
    pulse_done(18'd12);
    step();
    check("ovf_set", overflow, 1);
    check("ovf_hold_valid", m_valid, 1);
    check("ovf_hold_data", m_data, 32'd10);
    m_ready = 1'b1;
    step();
    pulse_done(18'd13);
    pulse_done(18'd14);
    wait_done(d0 + 1, 50, ok);
    check("ovf_done_seen", ok, 1);
    check("ovf_beats", beat_q.size() - b0, 3);
    for (int k = 0; k < 3 && b0 + k < beat_q.size(); k++) begin
      check($sformatf("ovf_data_%0d", k), beat_q[b0 + k], (k == 0) ? 32'd10 : 32'(12 + k));
      check($sformatf("ovf_last_%0d", k), last_q[b0 + k], (k == 2) ? 1 : 0);
    end

    // Start coincident with a done: only the result that reaches S2 in CAP_RUN streams.
    b0 = beat_q.size(); d0 = done_cnt;
    step();
    done_man = 1'b1; raw_man = 18'd50;
    step();
    cap_start = 1'b1; ddr_size = 15'd1; raw_man = 18'd51;
    step();
    cap_start = 1'b0; done_man = 1'b0;
    wait_done(d0 + 1, 50, ok);
    check("sim_done_seen", ok, 1);
    check("sim_beats", beat_q.size() - b0, 1);
    if (beat_q.size() > b0) begin
      check("sim_data", beat_q[b0], 32'd51);
      check("sim_last", last_q[b0], 1);
    end
    check("sim_overflow_cleared", overflow, 0);

    // Asynchronous reset mid-capture, then a fresh capture.
    b0 = beat_q.size();
    start_cap(15'd6);
    pulse_done(18'd100);
    pulse_done(18'd101);
    repeat (3) step();
    check("abort_pre_beats", beat_q.size() - b0, 2);
    m_ready = 1'b0;
    pulse_done(18'd102);
    repeat (2) step();
    check("abort_pending_valid", m_valid, 1);
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    check("abort_flags", {27'd0, m_valid, m_last, cap_busy, cap_done, overflow}, 32'd0);
    check("abort_data", m_data | adc_data, 32'd0);
    step();
    rst = 1'b0;
    repeat (3) step();
    check("abort_no_done", done_cnt - d0, 0);
    m_ready = 1'b1; b0 = beat_q.size(); d0 = done_cnt;
    start_cap(15'd3);
    pulse_done(18'd200);
    pulse_done(18'd201);
    pulse_done(18'd202);
    wait_done(d0 + 1, 50, ok);
    check("fresh_done_seen", ok, 1);
    check("fresh_beats", beat_q.size() - b0, 3);
    for (int k = 0; k < 3 && b0 + k < beat_q.size(); k++) begin
      check($sformatf("fresh_data_%0d", k), beat_q[b0 + k], 32'(200 + k));
      check($sformatf("fresh_last_%0d", k), last_q[b0 + k], (k == 2) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
